// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types and constants for the I2C bus arbiter.
//   - arbiter FSM state type and its 2-bit encodings
//   - Avalon-MM register index constants
//   - CTRL and STATUS bit positions
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    OWN     = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic [1:0] ADDR_CTRL       = 2'd0;
  localparam logic [1:0] ADDR_STATUS     = 2'd1;
  localparam logic [1:0] ADDR_SWITCH_CNT = 2'd2;
  localparam logic [1:0] ADDR_CNT_CLR    = 2'd3;

  localparam int CTRL_LOCK_EN_BIT    = 0;
  localparam int CTRL_LOCK_OWNER_BIT = 1;

  localparam int STAT_GNT_LSB        = 0;
  localparam int STAT_STATE_LSB      = 2;
  localparam int STAT_TIMEOUT_BIT    = 4;
  localparam int STAT_LAST_OWNER_BIT = 5;

endpackage

// File: rtl/i2c_bus_free_detect.sv
// i2c_bus_free_detect: counts consecutive cycles with SCL and SDA both high.
// The count saturates at IDLE_CYCLES; free is high while it sits there.
//   clk, reset_n : clock, async active-low reset
//   scl_in/sda_in: monitored bus levels
//   clr          : restart the count (used when the monitored bus changes)
//   free         : bus has been idle for IDLE_CYCLES cycles
module i2c_bus_free_detect #(
  parameter int IDLE_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  input  logic clr,
  output logic free
);

  localparam int CW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(IDLE_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || !(scl_in && sda_in)) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign free = (cnt == CNT_MAX);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: two-requester round-robin arbiter for a muxed I2C bus.
// A winner is selected onto the mux, the bus must then be seen idle for
// IDLE_CYCLES before the grant is issued; after release the bus must again
// be idle before the next arbitration.
//
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   address, chipselect,
//   write_n, writedata,
//   readdata            : Avalon-MM slave (CTRL, STATUS, SWITCH_CNT, CNT_CLR)
//   req / gnt           : per-requester request / grant
//   scl_in, sda_in      : levels of the currently selected bus
//   sel                 : mux select, index of the owning requester
//
// Build option: define I2C_ARB_TIMEOUT_EN to add a grant-hold timeout
// (TIMEOUT_CYCLES) with sticky STATUS flag and requester lockout.
//
// state   | meaning
// IDLE    | no owner, arbitrate eligible requests
// SETTLE  | sel switched to winner, waiting for bus-free
// OWN     | gnt high for the owner
// RELEASE | grant dropped, waiting for bus-free before next arbitration
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int IDLE_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sel
);

  arb_state_e state, state_nxt;
  logic       sel_nxt, last_owner, last_nxt;
  logic [1:0] gnt_nxt;
  logic       lock_en, lock_owner;
  logic [7:0] switch_cnt;
  logic       timeout_flag;
  logic [1:0] lock_mask, blk_mask, elig;
  logic       winner, sel_chg, free, to_expire, wr_en;

  assign wr_en     = chipselect && !write_n;
  assign lock_mask = lock_en ? (lock_owner ? 2'b10 : 2'b01) : 2'b11;
  assign elig      = req & lock_mask & blk_mask;
  // On a tie the requester that did not own the bus last wins.
  assign winner    = (&elig) ? ~last_owner : elig[1];
  assign sel_chg   = (sel_nxt != sel);

  i2c_bus_free_detect #(.IDLE_CYCLES(IDLE_CYCLES)) u_free (
    .clk     (clk),
    .reset_n (reset_n),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .clr     (sel_chg),
    .free    (free)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int HW = $clog2(TIMEOUT_CYCLES + 1);
  logic [HW-1:0] hold_cnt;
  logic [1:0]    to_blk;
  logic          to_hit;
  logic          unused_cfg;

  // hold_cnt is 0 on the first OWN cycle, so gnt stays up TIMEOUT_CYCLES cycles.
  assign to_expire = (hold_cnt == HW'(TIMEOUT_CYCLES - 1));
  assign to_hit    = (state == OWN) && req[sel] && to_expire;
  assign blk_mask  = ~to_blk;
  assign unused_cfg = ^{writedata[7:5], writedata[3:2]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt     <= '0;
      to_blk       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      hold_cnt <= (state == OWN && state_nxt == OWN) ? hold_cnt + HW'(1) : '0;
      // Lockout lasts until the timed-out requester is seen with req low.
      to_blk   <= (to_blk & req) | ({2{to_hit}} & (sel ? 2'b10 : 2'b01));
      if (to_hit) begin
        timeout_flag <= 1'b1;
      end else if (wr_en && address == ADDR_STATUS && writedata[STAT_TIMEOUT_BIT]) begin
        timeout_flag <= 1'b0;
      end
    end
  end
`else
  logic unused_cfg;
  assign to_expire    = 1'b0;
  assign timeout_flag = 1'b0;
  assign blk_mask     = 2'b11;
  assign unused_cfg   = ^{writedata[7:2], (TIMEOUT_CYCLES != 0)};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel        <= 1'b0;
      gnt        <= 2'b00;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      gnt        <= gnt_nxt;
      last_owner <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    gnt_nxt   = gnt;
    last_nxt  = last_owner;
    case (state)
      IDLE: begin
        if (|elig) begin
          sel_nxt   = winner;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (!req[sel]) begin
          state_nxt = IDLE;
        end else if (free) begin
          state_nxt = OWN;
          gnt_nxt   = sel ? 2'b10 : 2'b01;
        end
      end
      OWN: begin
        if (!req[sel] || to_expire) begin
          state_nxt = RELEASE;
          gnt_nxt   = 2'b00;
        end
      end
      RELEASE: begin
        if (free) begin
          state_nxt = IDLE;
          last_nxt  = sel;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_en    <= 1'b0;
      lock_owner <= 1'b0;
      switch_cnt <= 8'd0;
    end else begin
      if (wr_en && address == ADDR_CTRL) begin
        lock_en    <= writedata[CTRL_LOCK_EN_BIT];
        lock_owner <= writedata[CTRL_LOCK_OWNER_BIT];
      end
      // A clear write wins over a same-cycle select change.
      if (wr_en && address == ADDR_CNT_CLR) begin
        switch_cnt <= 8'd0;
      end else if (sel_chg) begin
        switch_cnt <= switch_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    readdata = 8'h00;
    case (address)
      ADDR_CTRL:       readdata = {6'b0, lock_owner, lock_en};
      ADDR_STATUS:     readdata = {2'b0, last_owner, timeout_flag, state, gnt};
      ADDR_SWITCH_CNT: readdata = switch_cnt;
      default:         readdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: self-checking bench for i2c_bus_arbiter with
// IDLE_CYCLES=4, TIMEOUT_CYCLES=16. A cycle-by-cycle vector table drives
// arbitration/handover; hand-written sequences cover settle restart,
// settle abort, lock, timeout (or its absence) and reset during a grant.
module tb_i2c_bus_arbiter;
  import i2c_arb_pkg::*;

  localparam int IDLE_N = 4;
  localparam int TO_N   = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] address = 2'd0;
  logic       chipselect = 1'b0;
  logic       write_n = 1'b1;
  logic [7:0] writedata = 8'h00;
  logic [7:0] readdata;
  logic [1:0] req = 2'b00;
  logic [1:0] gnt;
  logic       scl_in = 1'b1;
  logic       sda_in = 1'b1;
  logic       sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.IDLE_CYCLES(IDLE_N), .TIMEOUT_CYCLES(TO_N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .req        (req),
    .gnt        (gnt),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sel        (sel)
  );

  typedef struct {
    logic [1:0] req;
    logic       scl;
    logic       sda;
    logic [1:0] gnt;
    logic       sel;
    logic [1:0] st;
    logic [7:0] sw;
  } vec_t;

  typedef struct {
    int         idx;
    logic [1:0] gnt;
    logic       sel;
    logic [1:0] st;
    logic [7:0] sw;
  } exp_t;

  vec_t tbl[15];
  exp_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [7:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // Called and returns at a negedge; the write lands on the posedge between.
  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = 2'b00; scl_in = 1'b1; sda_in = 1'b1;
    chipselect = 1'b0; write_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Counts posedges until gnt is non-zero (bounded); returns at a negedge.
  task automatic wait_gnt(input int lim, output int n);
    n = 0;
    while (n < lim) begin
      @(posedge clk);
      #1;
      n++;
      if (gnt != 2'b00) break;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] rd, st_rd, sw_rd;
    int n, bad, hc;
    exp_t e;

    //         req    scl   sda   gnt    sel   st     sw
    tbl[0]  = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 2'd1, 8'd0};
    tbl[1]  = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 2'd1, 8'd0};
    tbl[2]  = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 2'd1, 8'd0};
    tbl[3]  = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 2'd1, 8'd0};
    tbl[4]  = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b0, 2'd2, 8'd0};
    tbl[5]  = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b0, 2'd2, 8'd0};
    tbl[6]  = '{2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 2'd3, 8'd0};
    tbl[7]  = '{2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 8'd0};
    tbl[8]  = '{2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 2'd1, 8'd1};
    tbl[9]  = '{2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 2'd1, 8'd1};
    tbl[10] = '{2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 2'd1, 8'd1};
    tbl[11] = '{2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 2'd1, 8'd1};
    tbl[12] = '{2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 2'd1, 8'd1};
    tbl[13] = '{2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 2'd2, 8'd1};
    tbl[14] = '{2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 2'd2, 8'd1};

    // Reset state
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    reg_rd(ADDR_STATUS, rd);
    chk("rst_status", 32'(rd), 32'h20);
    reg_rd(ADDR_CTRL, rd);
    chk("rst_ctrl", 32'(rd), 32'h00);
    reg_rd(ADDR_SWITCH_CNT, rd);
    chk("rst_swcnt", 32'(rd), 32'h00);

    // Tie after reset goes to 0, then handover to requester 1
    for (int i = 0; i < 15; i++) begin
      req    = tbl[i].req;
      scl_in = tbl[i].scl;
      sda_in = tbl[i].sda;
      sb_q.push_back('{i, tbl[i].gnt, tbl[i].sel, tbl[i].st, tbl[i].sw});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      reg_rd(ADDR_STATUS, st_rd);
      reg_rd(ADDR_SWITCH_CNT, sw_rd);
      chk($sformatf("vec%0d_gnt", e.idx), 32'(gnt), 32'(e.gnt));
      chk($sformatf("vec%0d_sel", e.idx), 32'(sel), 32'(e.sel));
      chk($sformatf("vec%0d_state", e.idx), 32'(st_rd[3:2]), 32'(e.st));
      chk($sformatf("vec%0d_swcnt", e.idx), 32'(sw_rd), 32'(e.sw));
      @(negedge clk);
    end
    reg_rd(ADDR_STATUS, rd);
    chk("last_owner_after_handover", 32'(rd[5]), 32'h0);
    reg_wr(ADDR_CNT_CLR, 8'h5A);
    reg_rd(ADDR_SWITCH_CNT, rd);
    chk("swcnt_cleared", 32'(rd), 32'h0);

    // SDA low pulse in SETTLE restarts the bus-free count
    do_reset();
    req = 2'b01;
    @(posedge clk);
    #1;
    reg_rd(ADDR_STATUS, rd);
    chk("pulse_settle_entry", 32'(rd[3:2]), 32'd1);
    @(negedge clk);
    sda_in = 1'b0;
    repeat (2) @(negedge clk);
    sda_in = 1'b1;
    wait_gnt(20, n);
    chk("pulse_gnt_delay", 32'(n), 32'(IDLE_N + 1));
    chk("pulse_gnt", 32'(gnt), 32'h1);

    // Winner drops req during SETTLE: back to IDLE, no grant
    do_reset();
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    @(posedge clk);
    #1;
    reg_rd(ADDR_STATUS, rd);
    chk("abort_state", 32'(rd[3:2]), 32'd0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (gnt != 2'b00) bad++;
    end
    @(negedge clk);
    chk("abort_no_gnt", 32'(bad), 32'd0);

    // Lock to requester 1
    do_reset();
    reg_wr(ADDR_CTRL, 8'h03);
    reg_rd(ADDR_CTRL, rd);
    chk("ctrl_readback", 32'(rd), 32'h03);
    req = 2'b11;
    wait_gnt(30, n);
    chk("lock_gnt", 32'(gnt), 32'h2);
    chk("lock_sel", 32'(sel), 32'h1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (gnt !== 2'b10) bad++;
    end
    @(negedge clk);
    chk("lock_hold", 32'(bad), 32'd0);
    req = 2'b01;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (gnt[0]) bad++;
    end
    @(negedge clk);
    chk("lock_req0_ignored", 32'(bad), 32'd0);
    reg_rd(ADDR_STATUS, rd);
    chk("lock_idle_state", 32'(rd[3:0]), 32'h0);
    reg_wr(ADDR_CTRL, 8'h00);
    wait_gnt(30, n);
    chk("unlock_gnt", 32'(gnt), 32'h1);
    reg_wr(ADDR_CTRL, 8'h03);
    repeat (5) @(negedge clk);
    chk("lock_no_preempt", 32'(gnt), 32'h1);

`ifdef I2C_ARB_TIMEOUT_EN
    // Requester 1 overstays its grant
    do_reset();
    req = 2'b10;
    wait_gnt(30, n);
    chk("to_gnt", 32'(gnt), 32'h2);
    hc = 1;
    while (hc < 40) begin
      @(posedge clk);
      #1;
      if (gnt == 2'b00) break;
      hc++;
    end
    @(negedge clk);
    chk("to_hold_len", 32'(hc), 32'(TO_N));
    reg_rd(ADDR_STATUS, rd);
    chk("to_flag_set", 32'(rd[4]), 32'h1);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (gnt != 2'b00) bad++;
    end
    @(negedge clk);
    chk("to_no_regrant", 32'(bad), 32'd0);
    req = 2'b00;
    @(negedge clk);
    req = 2'b10;
    wait_gnt(30, n);
    chk("to_regrant", 32'(gnt), 32'h2);
    reg_rd(ADDR_STATUS, rd);
    chk("to_flag_sticky", 32'(rd[4]), 32'h1);
    reg_wr(ADDR_STATUS, 8'h10);
    reg_rd(ADDR_STATUS, rd);
    chk("to_flag_clear", 32'(rd[4]), 32'h0);
`else
    // Without the timeout build a long hold is never cut short
    do_reset();
    req = 2'b10;
    wait_gnt(30, n);
    chk("hold_gnt", 32'(gnt), 32'h2);
    bad = 0;
    for (int i = 0; i < 3 * TO_N; i++) begin
      @(posedge clk);
      #1;
      if (gnt !== 2'b10) bad++;
    end
    @(negedge clk);
    chk("hold_no_timeout", 32'(bad), 32'd0);
    reg_rd(ADDR_STATUS, rd);
    chk("hold_flag_zero", 32'(rd[4]), 32'h0);
`endif

    // Reset asserted during OWN
    do_reset();
    req = 2'b10;
    wait_gnt(30, n);
    chk("rstown_gnt_before", 32'(gnt), 32'h2);
    chk("rstown_sel_before", 32'(sel), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstown_gnt", 32'(gnt), 32'h0);
    chk("rstown_sel", 32'(sel), 32'h0);
    reg_rd(ADDR_STATUS, rd);
    chk("rstown_state", 32'(rd[3:2]), 32'd0);
    @(negedge clk);
    req = 2'b00;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 The block SHALL have parameter IDLE_CYCLES, default 64: consecutive cycles with SCL and SDA both high that count as bus-free.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum grant hold time, used only when the timeout feature is built.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port address, input, 2 bits: Avalon-MM slave register index.
REQ-006 The block SHALL have ports chipselect, input, 1 bit, and write_n, input, 1 bit: Avalon-MM write strobe, active when chipselect=1 and write_n=0.
REQ-007 The block SHALL have ports writedata, input, 8 bits, and readdata, output, 8 bits: Avalon-MM data.
REQ-008 The block SHALL have ports req, input, 2 bits, and gnt, output, 2 bits: per-requester bus request and bus grant.
REQ-009 The block SHALL have ports scl_in, input, 1 bit, and sda_in, input, 1 bit: monitored levels of the currently selected bus.
REQ-010 The block SHALL have port sel, output, 1 bit: bus/clock select driven to the I2C mux, where the value is the owning requester index.

Function
REQ-011 The block SHALL have FSM states IDLE, SETTLE, OWN and RELEASE.
REQ-012 The bus-free counter SHALL increment while scl_in=1 and sda_in=1, saturate at IDLE_CYCLES, clear on any low level, and clear on the cycle sel changes.
REQ-013 In IDLE with an eligible req, the FSM SHALL pick a winner, register sel to the winner next cycle and enter SETTLE.
REQ-014 Arbitration SHALL be round-robin: when both requesters are eligible, the winner is the one not equal to last_owner.
REQ-015 SETTLE SHALL go to OWN on the cycle the bus-free counter equals IDLE_CYCLES, and gnt[winner] SHALL be registered high on entry to OWN.
REQ-016 The winner dropping req while in SETTLE SHALL cause a return to IDLE with no grant issued.
REQ-017 In OWN, a deasserted req SHALL cause entry to RELEASE with gnt cleared in the same registered update, one cycle after req falls.
REQ-018 RELEASE SHALL return to IDLE when the bus-free counter equals IDLE_CYCLES, and last_owner SHALL be updated on that transition.
REQ-019 gnt SHALL be one-hot or zero at all times, and SHALL never be high outside OWN.
REQ-020 sel SHALL change only on the IDLE-to-SETTLE transition and SHALL hold its value in all other states.
REQ-021 Register 0 (CTRL, read/write) SHALL hold bit0 lock_en and bit1 lock_owner; when locked, only req[lock_owner] is eligible.
REQ-022 Setting lock never SHALL preempt a current owner; the lock SHALL take effect at the next IDLE arbitration.
REQ-023 Register 1 (STATUS, read-only) SHALL report bits[1:0] gnt, bits[3:2] FSM state code, bit4 timeout_flag and bit5 last_owner; writes SHALL be ignored except as given in REQ-031.
REQ-024 Register 2 (SWITCH_CNT, read-only) SHALL be an 8-bit count of sel changes that wraps 255 to 0.
REQ-025 Any write to register 3 SHALL clear SWITCH_CNT, and a same-cycle increment SHALL be lost to the clear.
REQ-026 readdata SHALL be a combinational decode of address, with register 3 reading as 0.

Reset
REQ-027 While reset_n=0, the block SHALL force: state IDLE; gnt 0; sel 0; last_owner 1, so requester 0 wins the first tie; CTRL 0; SWITCH_CNT 0; timeout_flag 0; bus-free counter 0.
REQ-028 Reset asserted mid-grant SHALL drop gnt asynchronously without waiting for bus-free.

Configuration
REQ-029 Macro I2C_ARB_TIMEOUT_EN defined SHALL build a grant-hold counter that, on reaching TIMEOUT_CYCLES in OWN, clears gnt, enters RELEASE and sets the sticky timeout_flag.
REQ-030 With I2C_ARB_TIMEOUT_EN defined, a timed-out requester SHALL be ineligible until its req has been observed low for at least one cycle.
REQ-031 With I2C_ARB_TIMEOUT_EN defined, writing 1 to STATUS bit4 SHALL clear timeout_flag.
REQ-032 With I2C_ARB_TIMEOUT_EN undefined, there SHALL be no hold counter, STATUS bit4 SHALL read 0, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-033 Package i2c_arb_pkg SHALL hold the FSM state typedef and its 2-bit encodings, the register address constants (CTRL=0, STATUS=1, SWITCH_CNT=2, CNT_CLR=3) and the CTRL/STATUS bit positions.
REQ-034 The bus-free counter SHALL be a sub-module named i2c_bus_free_detect, with inputs clk, reset_n, scl_in, sda_in and clr, and output free.

Verification (IDLE_CYCLES=4, TIMEOUT_CYCLES=16)
REQ-035 Scenario: after reset, req=2'b11 with bus idle -> sel=0 and gnt=2'b01 appear 4 cycles after settle entry, and SWITCH_CNT stays 0.
REQ-036 Scenario: requester 0 releases while req[1] stays high -> RELEASE, then sel=1 and gnt=2'b10, and SWITCH_CNT=1.
REQ-037 Scenario: sda_in pulsed low during SETTLE -> the counter restarts and gnt is delayed by the pulse plus 4 cycles.
REQ-038 Scenario: CTRL=8'h03 with req=2'b11 -> only gnt=2'b10 is ever issued, and req[0] is ignored.
REQ-039 Scenario (timeout build): requester 1 holds req for 20 cycles -> gnt drops at cycle 16, STATUS bit4=1, no regrant until req[1] falls, and a write of 8'h10 to STATUS clears bit4.
REQ-040 Scenario: reset_n pulsed low during OWN -> gnt=0 and sel=0 immediately, and the state reads IDLE.
